// File: rtl/instr_loader.sv
// instr_loader: fills the byte-wide instruction memory from the UART byte
// stream. Each load starts on i_start. Every received byte is written to the
// next address, and each group of four bytes forms a big-endian word. A load
// ends when the HALT word has been written (o_done) or when the address space
// fills up without a HALT (sticky o_error).
module instr_loader #(
    parameter int                  MEMORY_WIDTH   = 8,
    parameter int                  NB_ADDR_DEPTH  = 8,
    parameter int                  NB_INSTRUCTION = 32,
    parameter logic [NB_INSTRUCTION-1:0] HALT_INSTR = 32'hFFFFFFFF
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [MEMORY_WIDTH-1:0]  i_rx_data,
    input  logic                     i_rx_done,
    output logic                     o_write_enable,
    output logic [MEMORY_WIDTH-1:0]  o_write_data,
    output logic [NB_ADDR_DEPTH-1:0] o_write_addr,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    output logic [NB_ADDR_DEPTH-1:0] o_instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [NB_ADDR_DEPTH-1:0]  addr;
    logic [1:0]                byte_idx;
    logic [NB_INSTRUCTION-1:0] asm_word;

    // A start request only counts while no load is running; a byte only
    // counts while the loader is waiting for one. Anything else is dropped.
    logic start_accept;
    logic byte_accept;

    assign start_accept = i_start && ((state == IDLE) || (state == ERROR));
    assign byte_accept  = i_rx_done && (state == WAIT_BYTE);

    // State register.
    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before the clock edge.
        if (i_reset) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic. HALT takes priority over a wrapped address.
    always_comb begin
        // NOTE: the default assignment comes first, so every path assigns
        // next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:      if (i_start) next_state = WAIT_BYTE;
            WAIT_BYTE: if (i_rx_done) next_state = WRITE;
            WRITE:     next_state = (byte_idx == 2'd0) ? CHECK : WAIT_BYTE;
            CHECK: begin
                if (asm_word == HALT_INSTR) next_state = DONE;
                else if (addr == '0)        next_state = ERROR;
                else                        next_state = WAIT_BYTE;
            end
            DONE:      next_state = IDLE;
            ERROR:     if (i_start) next_state = WAIT_BYTE;
            default:   next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs. Outputs are derived from next_state,
    // so each one takes effect in the same cycle as the state it belongs to.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_write_enable <= 1'b0;
            o_write_data   <= '0;
            o_write_addr   <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_instr_count  <= '0;
            addr           <= '0;
            byte_idx       <= 2'd0;
            asm_word       <= '0;
        end else begin
            o_write_enable <= byte_accept;
            o_done         <= (next_state == DONE);
            o_error        <= (next_state == ERROR);
            o_busy         <= (next_state == WAIT_BYTE) || (next_state == WRITE)
                              || (next_state == CHECK);

            if (start_accept) begin
                addr          <= '0;
                byte_idx      <= 2'd0;
                asm_word      <= '0;
                o_instr_count <= '0;
            end

            // The first byte of a word ends up in the top bits (big-endian).
            if (byte_accept) begin
                o_write_data <= i_rx_data;
                o_write_addr <= addr;
                asm_word     <= {asm_word[NB_INSTRUCTION-MEMORY_WIDTH-1:0], i_rx_data};
                byte_idx     <= byte_idx + 2'd1;
            end

            // The address wraps naturally, and CHECK uses the wrap to detect
            // that the memory is full.
            if (state == WRITE) addr <= addr + 1'b1;

            if (state == CHECK) o_instr_count <= o_instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader. A monitor logs every memory write and
// counts o_done pulses. The main sequence drives loads and compares against
// hand-computed expectations.
module tb_instr_loader;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       o_write_enable;
    logic [7:0] o_write_data;
    logic [7:0] o_write_addr;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [7:0] o_instr_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] log_addr [$];
    logic [7:0] log_data [$];
    int         done_count = 0;

    instr_loader dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .o_write_enable(o_write_enable),
        .o_write_data  (o_write_data),
        .o_write_addr  (o_write_addr),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_instr_count (o_instr_count)
    );

    always #5 i_clock = ~i_clock;

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge i_clock) begin
        if (o_write_enable) begin
            log_addr.push_back(o_write_addr);
            log_data.push_back(o_write_data);
        end
        if (o_done) done_count++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_write(input int idx, input logic [7:0] addr, input logic [7:0] data);
        if (idx < log_addr.size()) begin
            check($sformatf("write[%0d].addr", idx), log_addr[idx], addr);
            check($sformatf("write[%0d].data", idx), log_data[idx], data);
        end else begin
            check($sformatf("write[%0d] present", idx), log_addr.size(), idx + 1);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_count = 0;
    endtask

    // One strobe, then 3 idle cycles between strobes.
    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clock);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clock);
        i_rx_done = 1'b0;
        repeat (3) @(negedge i_clock);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        @(negedge i_clock);
        i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
    endtask

    logic [7:0] t1_bytes [12];

    initial begin
        i_reset   = 1'b1;
        i_start   = 1'b0;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        t1_bytes  = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'hFF, 8'hFF, 8'hFF, 8'hFF};
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;

        // Reset state.
        check("rst.write_enable", o_write_enable, 1'b0);
        check("rst.write_data", o_write_data, 8'h00);
        check("rst.write_addr", o_write_addr, 8'h00);
        check("rst.busy", o_busy, 1'b0);
        check("rst.done", o_done, 1'b0);
        check("rst.error", o_error, 1'b0);
        check("rst.instr_count", o_instr_count, 8'h00);

        // A byte that arrives in IDLE is dropped.
        clear_log();
        send_byte(8'hAB);
        check("idle_byte.writes", log_addr.size(), 0);
        check("idle_byte.busy", o_busy, 1'b0);

        // Three-word load that ends with HALT.
        clear_log();
        pulse_start();
        check("t1.busy_after_start", o_busy, 1'b1);
        for (int i = 0; i < 12; i++) send_byte(t1_bytes[i]);
        repeat (3) @(negedge i_clock);
        check("t1.writes", log_addr.size(), 12);
        for (int i = 0; i < 12; i++) check_write(i, 8'(i), t1_bytes[i]);
        check("t1.instr_count", o_instr_count, 8'd3);
        check("t1.done_pulses", done_count, 1);
        check("t1.busy_after", o_busy, 1'b0);
        check("t1.error", o_error, 1'b0);

        // Fill all 256 bytes without a HALT: error, no done.
        clear_log();
        pulse_start();
        for (int w = 0; w < 64; w++) send_word(32'h00000001);
        repeat (3) @(negedge i_clock);
        check("fill.writes", log_addr.size(), 256);
        for (int i = 0; i < 256; i++)
            check_write(i, 8'(i), ((i % 4) == 3) ? 8'h01 : 8'h00);
        check("fill.error", o_error, 1'b1);
        check("fill.instr_count", o_instr_count, 8'd64);
        check("fill.done_pulses", done_count, 0);
        check("fill.busy", o_busy, 1'b0);
        repeat (5) @(negedge i_clock);
        check("fill.error_sticky", o_error, 1'b1);

        // Restart from ERROR. A near-HALT word must not end the load.
        clear_log();
        pulse_start();
        check("near.error_cleared", o_error, 1'b0);
        check("near.busy", o_busy, 1'b1);
        send_word(32'hFFFFFF00);
        check("near.no_early_done", done_count, 0);
        check("near.busy_mid", o_busy, 1'b1);
        send_word(32'hFFFFFFFF);
        repeat (3) @(negedge i_clock);
        check("near.writes", log_addr.size(), 8);
        check_write(0, 8'd0, 8'hFF);
        check_write(3, 8'd3, 8'h00);
        check_write(7, 8'd7, 8'hFF);
        check("near.done_pulses", done_count, 1);
        check("near.instr_count", o_instr_count, 8'd2);
        check("near.error", o_error, 1'b0);

        // Reset in the middle of a load.
        clear_log();
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        check("midrst.busy", o_busy, 1'b0);
        check("midrst.write_addr", o_write_addr, 8'h00);
        check("midrst.write_data", o_write_data, 8'h00);
        check("midrst.instr_count", o_instr_count, 8'h00);
        check("midrst.write_enable", o_write_enable, 1'b0);
        clear_log();
        pulse_start();
        send_word(32'hFFFFFFFF);
        repeat (3) @(negedge i_clock);
        check("midrst.writes", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) check_write(i, 8'(i), 8'hFF);
        check("midrst.instr_count_after", o_instr_count, 8'd1);
        check("midrst.done_pulses", done_count, 1);

        // A start request during a load is ignored.
        clear_log();
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        pulse_start();
        send_byte(8'h56);
        send_byte(8'h78);
        send_word(32'hFFFFFFFF);
        repeat (3) @(negedge i_clock);
        check("busystart.writes", log_addr.size(), 8);
        check_write(0, 8'd0, 8'h12);
        check_write(2, 8'd2, 8'h56);
        check_write(3, 8'd3, 8'h78);
        check_write(4, 8'd4, 8'hFF);
        check_write(7, 8'd7, 8'hFF);
        check("busystart.instr_count", o_instr_count, 8'd2);
        check("busystart.done_pulses", done_count, 1);
        check("busystart.busy", o_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
